// File: rtl/dec_rr_arb8.sv
// dec_rr_arb8: 8-way round-robin arbiter; ports clk/rst, req[7:0], done in; gnt_valid, gnt_idx[2:0], gnt[7:0] one-hot, timeout pulse out
module dec_rr_arb8 #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           r_state, w_state_nx;
  logic [2:0]       r_ptr, w_ptr_nx, r_idx, w_idx_nx, w_off, w_pick;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [7:0]       r_gnt, w_gnt_nx, w_rot;
  logic [15:0]      w_dbl;
  logic             r_to, w_to_nx, w_start, w_rel, w_hold;
  assign w_dbl  = {req, req};
  assign w_rot  = w_dbl[r_ptr +: 8];
  assign w_pick = r_ptr + w_off;
  assign w_hold = (HOLD_MAX != 0) && (r_cnt == CNT_W'(HOLD_MAX));
  always_comb begin
    w_off = '0;
    for (int k = 7; k >= 0; k--)
      if (w_rot[k]) w_off = 3'(k);
  end
  always_comb begin
    w_start    = (r_state == IDLE) && |req;
    w_rel      = (r_state == GRANT) && (done || !req[r_idx] || w_hold);
    w_state_nx = w_start ? GRANT : w_rel ? IDLE : r_state;
    w_idx_nx   = w_start ? w_pick : r_idx;
    w_ptr_nx   = w_rel ? r_idx + 3'd1 : r_ptr;
    w_cnt_nx   = w_start ? CNT_W'(1)
               : (r_state == GRANT && !w_rel && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
    w_gnt_nx   = (w_state_nx == GRANT) ? 8'(1) << w_idx_nx : 8'h00;
    w_to_nx    = w_rel && !done && req[r_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_gnt   <= w_gnt_nx;
      r_to    <= w_to_nx;
    end
  end
  assign gnt_valid = (r_state == GRANT);
  assign gnt_idx   = r_idx;
  assign gnt       = r_gnt;
  assign timeout   = r_to;
endmodule

// File: tb/tb_dec_rr_arb8.sv
// tb_dec_rr_arb8: directed self-checking bench for dec_rr_arb8 with HOLD_MAX=4
module tb_dec_rr_arb8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_valid, timeout;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  int n_chk = 0;
  int n_err = 0;
  dec_rr_arb8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .gnt(gnt), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 8'(gnt_valid), 8'h00);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_idx", 8'(gnt_idx), 8'h00);
    chk("rst_to", 8'(timeout), 8'h00);
    req = 8'h08;
    tick;
    chk("single_idx", 8'(gnt_idx), 8'h03);
    chk("single_gnt", gnt, 8'h08);
    chk("single_valid", 8'(gnt_valid), 8'h01);
    done = 1'b1;
    tick;
    chk("single_rel_gnt", gnt, 8'h00);
    chk("single_rel_valid", 8'(gnt_valid), 8'h00);
    done = 1'b0;
    req = 8'h00;
    tick;
    req = 8'h20;
    tick;
    chk("mid_idx", 8'(gnt_idx), 8'h05);
    chk("mid_gnt", gnt, 8'h20);
    #3 rst = 1'b1;
    #1;
    chk("async_gnt", gnt, 8'h00);
    chk("async_valid", 8'(gnt_valid), 8'h00);
    chk("async_idx", 8'(gnt_idx), 8'h00);
    tick;
    rst = 1'b0;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("rot_idx", 8'(gnt_idx), 8'(i % 8));
      chk("rot_gnt", gnt, 8'h01 << (i % 8));
      done = 1'b1;
      tick;
      chk("rot_gap", 8'(gnt_valid), 8'h00);
      done = 1'b0;
    end
    req = 8'h40;
    tick;
    chk("wrap6_idx", 8'(gnt_idx), 8'h06);
    done = 1'b1;
    tick;
    done = 1'b0;
    req = 8'b1000_0011;
    tick;
    chk("wrap7_idx", 8'(gnt_idx), 8'h07);
    chk("wrap7_gnt", gnt, 8'h80);
    done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    chk("wrap0_idx", 8'(gnt_idx), 8'h00);
    chk("wrap0_gnt", gnt, 8'h01);
    done = 1'b1;
    tick;
    done = 1'b0;
    req = 8'h04;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("hold_gnt", gnt, 8'h04);
      chk("hold_to", 8'(timeout), 8'h00);
    end
    tick;
    chk("to_gnt", gnt, 8'h00);
    chk("to_pulse", 8'(timeout), 8'h01);
    tick;
    chk("regrant_idx", 8'(gnt_idx), 8'h02);
    chk("regrant_valid", 8'(gnt_valid), 8'h01);
    chk("to_clear", 8'(timeout), 8'h00);
    done = 1'b1;
    tick;
    done = 1'b0;
    req = 8'h02;
    tick;
    chk("wd_idx", 8'(gnt_idx), 8'h01);
    req = 8'h00;
    tick;
    chk("wd_valid", 8'(gnt_valid), 8'h00);
    chk("wd_to", 8'(timeout), 8'h00);
    req = 8'h08;
    tick;
    chk("co_idx", 8'(gnt_idx), 8'h03);
    repeat (3) tick;
    done = 1'b1;
    tick;
    chk("co_valid", 8'(gnt_valid), 8'h00);
    chk("co_to", 8'(timeout), 8'h00);
    req = 8'h00;
    tick;
    tick;
    chk("idle_done", 8'(gnt_valid), 8'h00);
    done = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
